// File: rtl/uart_cmd_parser.sv
// Assembles 5-byte command frames (HEADER, ADDR, DATA_HI, DATA_LO, CSUM) from a UART
// byte stream and presents each checksum-verified register write on a valid/ready port.
module uart_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000,
  parameter logic [7:0]  HEADER         = 8'h55
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        frame_err,
  output logic [1:0]  err_code
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_CHECKSUM = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_OVERFLOW = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DHI,
    S_DLO,
    S_CSUM
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    dhi_q, dhi_d;
  logic [7:0]    dlo_q, dlo_d;
  logic [7:0]    xor_q, xor_d;
  logic [7:0]    cmd_addr_q, cmd_addr_d;
  logic [15:0]   cmd_data_q, cmd_data_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    err_code_q, err_code_d;

  // NOTE: every signal written here gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    dhi_d       = dhi_q;
    dlo_d       = dlo_q;
    xor_d       = xor_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    cmd_valid_d = cmd_valid_q;
    frame_err_d = 1'b0;
    err_code_d  = ERR_NONE;

    if (cmd_valid_q && cmd_ready) begin
      cmd_valid_d = 1'b0;
    end

    if (rx_valid || state_q == S_IDLE) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    if (rx_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_data == HEADER) state_d = S_ADDR;
        end
        S_ADDR: begin
          addr_d  = rx_data;
          xor_d   = rx_data;
          state_d = S_DHI;
        end
        S_DHI: begin
          dhi_d   = rx_data;
          xor_d   = xor_q ^ rx_data;
          state_d = S_DLO;
        end
        S_DLO: begin
          dlo_d   = rx_data;
          xor_d   = xor_q ^ rx_data;
          state_d = S_CSUM;
        end
        S_CSUM: begin
          state_d = S_IDLE;
          if (rx_data != xor_q) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHECKSUM;
          end else if (!cmd_valid_q || cmd_ready) begin
            // A slot freed by this cycle's handshake is reused immediately.
            cmd_addr_d  = addr_q;
            cmd_data_d  = {dhi_q, dlo_q};
            cmd_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_OVERFLOW;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && cnt_q == CNT_LAST) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      frame_err_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      dhi_q       <= '0;
      dlo_q       <= '0;
      xor_q       <= '0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      dhi_q       <= dhi_d;
      dlo_q       <= dlo_d;
      xor_q       <= xor_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign cmd_addr  = cmd_addr_q;
  assign cmd_data  = cmd_data_q;
  assign cmd_valid = cmd_valid_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser with the inter-byte timeout
// shortened to 100 cycles.
module tb_uart_cmd_parser;

  localparam int unsigned TO = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic        frame_err;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_fail   = 0;

  uart_cmd_parser #(
    .TIMEOUT_CYCLES(TO),
    .HEADER        (8'h55)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .cmd_addr (cmd_addr),
    .cmd_data (cmd_data),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .frame_err(frame_err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic check_cmd(input string tag, input logic v, input logic [7:0] a, input logic [15:0] d);
    check({tag, ".valid"}, 32'(cmd_valid), 32'(v));
    check({tag, ".addr"},  32'(cmd_addr),  32'(a));
    check({tag, ".data"},  32'(cmd_data),  32'(d));
  endtask

  task automatic check_err(input string tag, input logic e, input logic [1:0] c);
    check({tag, ".err"}, 32'(frame_err), 32'(e));
    if (e) check({tag, ".code"}, 32'(err_code), 32'(c));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check_cmd("reset", 1'b0, 8'h00, 16'h0000);
    check_err("reset", 1'b0, 2'b00);
    check("reset.code", 32'(err_code), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Good frame with ready high: one-cycle valid pulse
    send(8'h55); send(8'h03); send(8'h12); send(8'h34);
    check("good.pre_valid", 32'(cmd_valid), 32'h0);
    send(8'h25);
    check_cmd("good", 1'b1, 8'h03, 16'h1234);
    check_err("good", 1'b0, 2'b00);
    tick();
    check("good.valid_drop", 32'(cmd_valid), 32'h0);

    // Bad checksum, then a good frame is accepted
    send(8'h55); send(8'h03); send(8'h12); send(8'h34); send(8'h26);
    check_err("badcs", 1'b1, 2'b01);
    check("badcs.valid", 32'(cmd_valid), 32'h0);
    tick();
    check_err("badcs.after", 1'b0, 2'b00);
    send(8'h55); send(8'h07); send(8'hAB); send(8'hCD); send(8'h61);
    check_cmd("good2", 1'b1, 8'h07, 16'hABCD);
    check_err("good2", 1'b0, 2'b00);
    tick();

    // Leading garbage and header-valued payload bytes
    send(8'h00); send(8'hFF);
    send(8'h55); send(8'h55); send(8'h55); send(8'h55); send(8'h55);
    check_cmd("embhdr", 1'b1, 8'h55, 16'h5555);
    check_err("embhdr", 1'b0, 2'b00);
    tick();

    // Timeout after ADDR byte, tail bytes then ignored
    send(8'h55); send(8'h03);
    repeat (TO - 1) tick();
    check_err("to.before", 1'b0, 2'b00);
    tick();
    check_err("to.fire", 1'b1, 2'b10);
    tick();
    check_err("to.pulse_end", 1'b0, 2'b00);
    send(8'h12); send(8'h34); send(8'h25);
    check("to.tail_valid", 32'(cmd_valid), 32'h0);
    check_err("to.tail", 1'b0, 2'b00);

    // Byte landing exactly on the last count wins over the timeout
    send(8'h55); send(8'h03);
    repeat (TO - 1) tick();
    send(8'h12);
    check_err("to.edge_byte", 1'b0, 2'b00);
    send(8'h34); send(8'h25);
    check_cmd("to.edge_frame", 1'b1, 8'h03, 16'h1234);
    check_err("to.edge_frame", 1'b0, 2'b00);
    tick();

    // Back-pressure and overflow
    cmd_ready = 1'b0;
    send(8'h55); send(8'h01); send(8'h00); send(8'h10); send(8'h11);
    check_cmd("bp.first", 1'b1, 8'h01, 16'h0010);
    send(8'h55); send(8'h02); send(8'h00); send(8'h20);
    check_cmd("bp.held", 1'b1, 8'h01, 16'h0010);
    send(8'h22);
    check_err("bp.ovf", 1'b1, 2'b11);
    check_cmd("bp.ovf", 1'b1, 8'h01, 16'h0010);
    tick();
    check_err("bp.ovf_end", 1'b0, 2'b00);
    check("bp.still_valid", 32'(cmd_valid), 32'h1);
    cmd_ready = 1'b1;
    tick();
    check_cmd("bp.accept", 1'b0, 8'h01, 16'h0010);

    // Reset mid-frame
    send(8'h55); send(8'h03); send(8'h12);
    rst_n = 1'b0;
    #1;
    check_cmd("rst.mid", 1'b0, 8'h00, 16'h0000);
    check_err("rst.mid", 1'b0, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send(8'h34); send(8'h25);
    check_cmd("rst.mid_tail", 1'b0, 8'h00, 16'h0000);
    check_err("rst.mid_tail", 1'b0, 2'b00);

    // Reset while a command is pending
    cmd_ready = 1'b0;
    send(8'h55); send(8'h09); send(8'h00); send(8'h01); send(8'h08);
    check_cmd("rst.pend_pre", 1'b1, 8'h09, 16'h0001);
    rst_n = 1'b0;
    #1;
    check_cmd("rst.pend", 1'b0, 8'h00, 16'h0000);
    check_err("rst.pend", 1'b0, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    tick();
    send(8'h34); send(8'h25);
    check_cmd("rst.pend_tail", 1'b0, 8'h00, 16'h0000);
    check_err("rst.pend_tail", 1'b0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
